lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

HD44780-compatible character LCD controller, sitting directly downstream of the Niski CPU's memory-mapped LCD port. It drives LCD_RS_PIN, LCD_RW_PIN, LCD_E_PIN and LCD_DATA_PINS. After reset it runs the power-on initialisation sequence. It then accepts one command or data byte at a time over a valid/ready handshake and generates the 8-bit bus write timing, including the post-instruction execution delay.

## Interface
Parameters (all in clock cycles):
- SETUP_CYCLES, default 2: RS/DATA valid before E rises (tAS).
- E_PULSE_CYCLES, default 12: E high width (≥230 ns).
- CMD_WAIT_CYCLES, default 2000: execution wait for ordinary commands and data (≥40 µs).
- CLEAR_WAIT_CYCLES, default 82000: execution wait for clear/home (≥1.64 ms).
- INIT_WAIT_CYCLES, default 205000: wait after the first function set (≥4.1 ms).
- POWERUP_CYCLES, default 750000: idle time after reset (≥15 ms).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_rs  in  1  0 = instruction, 1 = data.
- req_data  in  8  byte to write.
- init_done  out  1  power-on sequence complete, sticky until reset.
- lcd_rs  out  1  to LCD RS.
- lcd_rw  out  1  to LCD RW, constant 0.
- lcd_e  out  1  to LCD E.
- lcd_data  out  8  to LCD DB7..DB0.

## Operation
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, req_ready=0, init_done=0, state POWERUP.
- State sequence: POWERUP → INIT_LOAD → SETUP → PULSE → HOLD → WAIT → (INIT_LOAD | IDLE). From IDLE, a handshake leads to SETUP.
- POWERUP: count POWERUP_CYCLES with all outputs at reset values.
- Init ROM (index 0..6), written internally with the same bus cycle as a host request and rs=0: 38, 38, 38, 38, 0C, 01, 06.
- Waits during init:
  - Index 0 waits INIT_WAIT_CYCLES.
  - Index 5 (01) waits CLEAR_WAIT_CYCLES.
  - All other indices wait CMD_WAIT_CYCLES.
- After index 6's wait, enter IDLE. init_done and req_ready assert together.
- IDLE: req_ready=1. A handshake is req_valid && req_ready on a rising edge. On a handshake, latch req_rs/req_data into lcd_rs/lcd_data and drop req_ready.
- Wait selection for a host request:
  - rs=0 and data[7:2]==0 (clear, home) uses CLEAR_WAIT_CYCLES.
  - Everything else uses CMD_WAIT_CYCLES.
- req_ready is 0 in every state except IDLE. A req_valid asserted outside IDLE is ignored, not queued.
- lcd_rs/lcd_data hold their value from SETUP until the next transaction latches new values.
- lcd_rw is never driven high. Busy-flag polling is not supported; fixed delays only.
- Reset mid-operation (any state): on the next edge, all outputs return to reset values, lcd_e falls immediately, and the sequence restarts from POWERUP.
- A single down-counter is shared by all timed states. Its width is $clog2 of the largest parameter plus 1. It is loaded on state entry and the state exits when the counter reads 0. No wrap.

## Timing
- All outputs are registered; no combinational input-to-output path.
- For a handshake at edge k:
  - lcd_rs/lcd_data are valid from cycle k+1.
  - lcd_e=1 during cycles k+1+SETUP_CYCLES through k+SETUP_CYCLES+E_PULSE_CYCLES.
  - HOLD lasts exactly 1 cycle with E low and data stable.
  - WAIT lasts W cycles.
  - req_ready rises at cycle k+1+SETUP_CYCLES+E_PULSE_CYCLES+1+W.
- Request throughput: one byte per SETUP+E_PULSE+1+W+1 cycles.
- Init completes SETUP/PULSE/HOLD timing per ROM entry, so init_done rises at POWERUP + 7·(S+P+1) + INIT_WAIT + CLEAR_WAIT + 5·CMD_WAIT + (number of state-entry cycles). The exact count comes from the model, and the bench checks it with ±0 tolerance.

## Structure
- Package niski_lcd_pkg holds:
  - the lcd_state_t enum (POWERUP, INIT_LOAD, SETUP, PULSE, HOLD, WAIT, IDLE);
  - the init ROM as a localparam array of 7 bytes;
  - the ROM length constant;
  - the is_long_cmd(rs, data) function.
- Single module. No sub-module; the counter and ROM are inline.

## Test plan
All scenarios use small parameters: SETUP=2, E_PULSE=3, CMD_WAIT=5, CLEAR_WAIT=20, INIT_WAIT=8, POWERUP=10.
- Reset then idle → lcd_e stays 0 for 10 cycles; exactly 7 E pulses with data 38,38,38,38,0C,01,06 and rs=0; init_done and req_ready rise together after the last wait.
- After init, send rs=1, data=41 at edge k → lcd_e high at cycles k+3..k+5; data stays 41 through k+6; req_ready returns at k+12.
- Send rs=0, data=01 → req_ready returns 15 cycles later than for data 41 (wait of 20 vs 5).
- Hold req_valid high with back-to-back bytes 48, 49 → two distinct E pulses; the second byte is latched only when req_ready=1; no byte is dropped or duplicated.
- Assert rst during PULSE of a host write → lcd_e=0 and req_ready=0 on the next edge; the full init sequence (7 pulses) repeats.
- Throughout all tests → lcd_rw never 1; lcd_e never changes on the same edge as lcd_data.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// niski_lcd_pkg: shared types and constants for the HD44780-style LCD
// controller.
//   lcd_state_t  - controller FSM states
//   INIT_ROM     - power-on instruction sequence, index 0 is sent first
//   is_long_cmd  - true for the clear/home instructions, which need the
//                  long execution wait
package niski_lcd_pkg;

  typedef enum logic [2:0] {
    POWERUP,
    INIT_LOAD,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    IDLE
  } lcd_state_t;

  localparam int INIT_ROM_LEN = 7;

  // Sequence: function set x4 (8-bit, 2 lines), display on, clear,
  // then entry mode increment. Element [0] is the first byte sent.
  localparam logic [INIT_ROM_LEN-1:0][7:0] INIT_ROM = {
    8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38, 8'h38
  };

  // Clear display (01) and return home (02/03) are the only instructions
  // with the ~1.64 ms execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-compatible character LCD write controller.
// After reset it idles for POWERUP_CYCLES, replays the init ROM, then
// accepts one instruction/data byte per valid/ready handshake and produces
// the 8-bit bus write: setup, E pulse, one hold cycle, execution wait.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready host handshake; req_rs (0 instr, 1 data), req_data
//   init_done       power-on sequence finished (sticky until reset)
//   lcd_rs, lcd_rw, lcd_e, lcd_data  registered LCD bus (lcd_rw tied 0)
module lcd_ctrl
  import niski_lcd_pkg::*;
#(
  parameter int SETUP_CYCLES      = 2,
  parameter int E_PULSE_CYCLES    = 12,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 82000,
  parameter int INIT_WAIT_CYCLES  = 205000,
  parameter int POWERUP_CYCLES    = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int MAX_A      = (SETUP_CYCLES > E_PULSE_CYCLES) ? SETUP_CYCLES : E_PULSE_CYCLES;
  localparam int MAX_B      = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int MAX_C      = (INIT_WAIT_CYCLES > POWERUP_CYCLES) ? INIT_WAIT_CYCLES : POWERUP_CYCLES;
  localparam int MAX_AB     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYCLES = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  // Counter load values: a timed state lasting N cycles is entered with N-1
  // and left on the cycle the counter reads 0.
  localparam logic [CW-1:0] LD_SETUP   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] LD_PULSE   = CW'(E_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] LD_CMD     = CW'(CMD_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] LD_CLEAR   = CW'(CLEAR_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] LD_INIT    = CW'(INIT_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] LD_POWERUP = CW'(POWERUP_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX   = 3'(INIT_ROM_LEN - 1);

  lcd_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    init_idx, init_idx_nxt;
  logic          e_nxt, rs_nxt, ready_nxt, done_nxt;
  logic [7:0]    data_nxt;
  logic [CW-1:0] wait_load;
  logic          handshake;

  assign lcd_rw    = 1'b0;
  assign handshake = req_valid && req_ready;

  // The first ROM write needs the long post-function-set wait; after that
  // the byte on the bus decides, so ROM entry 01 picks the clear wait too.
  always_comb begin
    if (!init_done && init_idx == 3'd0) wait_load = LD_INIT;
    else if (is_long_cmd(lcd_rs, lcd_data)) wait_load = LD_CLEAR;
    else wait_load = LD_CMD;
  end

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = (cnt != '0) ? cnt - CW'(1) : cnt;
    init_idx_nxt = init_idx;
    e_nxt        = lcd_e;
    rs_nxt       = lcd_rs;
    data_nxt     = lcd_data;
    ready_nxt    = req_ready;
    done_nxt     = init_done;

    case (state)
      POWERUP: if (cnt == '0) state_nxt = INIT_LOAD;
      INIT_LOAD: begin
        rs_nxt    = 1'b0;
        data_nxt  = INIT_ROM[init_idx];
        cnt_nxt   = LD_SETUP;
        state_nxt = SETUP;
      end
      SETUP: if (cnt == '0) begin
        e_nxt     = 1'b1;
        cnt_nxt   = LD_PULSE;
        state_nxt = PULSE;
      end
      PULSE: if (cnt == '0) begin
        e_nxt     = 1'b0;
        state_nxt = HOLD;
      end
      HOLD: begin
        cnt_nxt   = wait_load;
        state_nxt = WAIT;
      end
      WAIT: if (cnt == '0) begin
        if (!init_done && init_idx != LAST_IDX) begin
          init_idx_nxt = init_idx + 3'd1;
          state_nxt    = INIT_LOAD;
        end else begin
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      IDLE: if (handshake) begin
        rs_nxt    = req_rs;
        data_nxt  = req_data;
        ready_nxt = 1'b0;
        cnt_nxt   = LD_SETUP;
        state_nxt = SETUP;
      end
      default: state_nxt = POWERUP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= POWERUP;
      cnt       <= LD_POWERUP;
      init_idx  <= 3'd0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_idx  <= init_idx_nxt;
      lcd_e     <= e_nxt;
      lcd_rs    <= rs_nxt;
      lcd_data  <= data_nxt;
      req_ready <= ready_nxt;
      init_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: scoreboard bench for lcd_ctrl with small timing parameters.
// Cycle numbering: a handshake at edge k makes the period after edge k
// "cycle k+1"; at each falling edge that cycle number is cyc+1.
module tb_lcd_ctrl;

  localparam int S   = 2;
  localparam int P   = 3;
  localparam int CMD = 5;
  localparam int CLR = 20;
  localparam int IW  = 8;
  localparam int PU  = 10;
  localparam int INIT_LEN = PU + 7 * (S + P + 2) + IW + CLR + 5 * CMD;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  lcd_ctrl #(
    .SETUP_CYCLES     (S),
    .E_PULSE_CYCLES   (P),
    .CMD_WAIT_CYCLES  (CMD),
    .CLEAR_WAIT_CYCLES(CLR),
    .INIT_WAIT_CYCLES (IW),
    .POWERUP_CYCLES   (PU)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rs   (req_rs),
    .req_data (req_data),
    .init_done(init_done),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // Expected bus writes {rs, data}, in order.
  logic [8:0] sb_q[$];
  logic [7:0] rom_exp [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Monitor: each rising E is one bus write, compared against the scoreboard.
  logic       prev_e = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         e_rises = 0;
  int         first_rise = -1;
  int         last_rise = -1;
  int         last_fall = -1;
  always @(negedge clk) begin
    if (lcd_e !== prev_e && !rst_seen)
      check("data_stable_at_e_edge", lcd_data, prev_data);
    if (lcd_e && !prev_e) begin
      e_rises++;
      if (first_rise < 0) first_rise = cyc + 1;
      last_rise = cyc + 1;
      check("lcd_rw_low", lcd_rw, 1'b0);
      if (sb_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        logic [8:0] exp_w;
        exp_w = sb_q.pop_front();
        check("write_rs_data", {lcd_rs, lcd_data}, exp_w);
      end
    end
    if (!lcd_e && prev_e) last_fall = cyc + 1;
    prev_e    = lcd_e;
    prev_data = lcd_data;
  end

  // Called at a falling edge with rst high; releases reset and follows init.
  task automatic run_init(input string tag);
    int rel;
    int rises0;
    bit early;
    bit seen;
    rel        = cyc;
    rises0     = e_rises;
    first_rise = -1;
    early      = 1'b0;
    seen       = 1'b0;
    for (int i = 0; i < 7; i++) sb_q.push_back({1'b0, rom_exp[i]});
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (init_done) begin
        seen = 1'b1;
        break;
      end
      if (req_ready) early = 1'b1;
    end
    if (!seen) begin
      check({tag, "_init_timeout"}, 0, 1);
    end else begin
      check({tag, "_init_done_cycle"}, cyc + 1, (rel + 1) + INIT_LEN);
      check({tag, "_ready_with_done"}, req_ready, 1'b1);
    end
    check({tag, "_ready_before_done"}, early, 1'b0);
    check({tag, "_first_e_cycle"}, first_rise, (rel + 1) + PU + 1 + S);
    check({tag, "_init_pulses"}, e_rises - rises0, 7);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  // Called at a falling edge; returns k, the edge on which the handshake lands.
  task automatic send(input logic rs, input logic [7:0] d, input bit keep_valid, output int k);
    bit ok;
    ok        = 1'b0;
    req_rs    = rs;
    req_data  = d;
    req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("handshake_timeout", 0, 1);
      req_valid = 1'b0;
      k = -1;
    end else begin
      k = cyc + 1;
      sb_q.push_back({rs, d});
      @(negedge clk);
      if (!keep_valid) req_valid = 1'b0;
      check("ready_drops", req_ready, 1'b0);
    end
  endtask

  task automatic wait_ready(output int t);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("ready_timeout", 0, 1);
    t = cyc + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, k2, t, rises0;
    bit ok;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_rs    = 1'b0;
    req_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lcd_e", lcd_e, 1'b0);
    check("rst_ready", req_ready, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_lcd_data", lcd_data, 8'h00);
    check("rst_lcd_rs", lcd_rs, 1'b0);
    check("rst_lcd_rw", lcd_rw, 1'b0);
    run_init("boot");

    // Data write 'A': E high k+3..k+5, hold at k+6, ready back at k+12.
    send(1'b1, 8'h41, 1'b0, k);
    repeat (5) @(negedge clk);
    check("hold_data", lcd_data, 8'h41);
    check("hold_e_low", lcd_e, 1'b0);
    wait_ready(t);
    check("a_e_rise", last_rise, k + 3);
    check("a_e_fall", last_fall, k + 6);
    check("a_ready_back", t, k + 12);
    check("a_lcd_rs", lcd_rs, 1'b1);

    // Clear display: wait is 20 instead of 5.
    send(1'b0, 8'h01, 1'b0, k2);
    wait_ready(t);
    check("clr_e_rise", last_rise, k2 + 3);
    check("clr_ready_back", t, k2 + 27);

    // Back-to-back with req_valid held high.
    rises0 = e_rises;
    send(1'b1, 8'h48, 1'b1, k);
    req_data = 8'h49;
    send(1'b1, 8'h49, 1'b0, k2);
    check("b2b_spacing", k2 - k, 12);
    wait_ready(t);
    check("b2b_pulses", e_rises - rises0, 2);
    check("b2b_sb_empty", sb_q.size(), 0);

    // Reset during the E pulse of a host write.
    send(1'b1, 8'h55, 1'b0, k);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (lcd_e) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid_pulse_seen", ok, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_lcd_e", lcd_e, 1'b0);
    check("mid_rst_ready", req_ready, 1'b0);
    check("mid_rst_init_done", init_done, 1'b0);
    check("mid_rst_lcd_data", lcd_data, 8'h00);
    check("mid_rst_lcd_rs", lcd_rs, 1'b0);
    check("mid_rst_sb_empty", sb_q.size(), 0);
    run_init("rerun");

    send(1'b1, 8'h5A, 1'b0, k);
    wait_ready(t);
    check("post_ready_back", t, k + 12);
    check("final_sb_empty", sb_q.size(), 0);
    check("final_lcd_rw", lcd_rw, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
